// File: rtl/mem_stage_vlat.sv
// MEM pipeline stage for a variable-latency data SRAM.
// Holds one instruction, waits for its data_ok, formats load data, forwards
// the result to ID and passes an opaque sideband to WB. Responses belonging
// to flushed instructions are counted and silently discarded.
module mem_stage_vlat #(
  parameter int PC_W       = 32,
  parameter int DEST_W     = 5,
  parameter int SIDE_W     = 79,
  parameter int MAX_CANCEL = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_allowin,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              in_gr_we,
  input  logic [DEST_W-1:0] in_dest,
  input  logic [31:0]       in_alu_res,
  input  logic [4:0]        in_load_op,
  input  logic              in_rfrom_mem,
  input  logic              in_req_sent,
  input  logic [SIDE_W-1:0] in_side,
  input  logic              data_ok,
  input  logic [31:0]       rdata,
  output logic              out_valid,
  input  logic              out_allowin,
  output logic [PC_W-1:0]   out_pc,
  output logic              out_gr_we,
  output logic [DEST_W-1:0] out_dest,
  output logic [SIDE_W-1:0] out_side,
  output logic [31:0]       out_result,
  output logic [DEST_W-1:0] fwd_dest,
  output logic              fwd_stall,
  output logic [31:0]       fwd_data
);

  localparam int CW = $clog2(MAX_CANCEL + 1);

  logic              r_valid;
  logic [PC_W-1:0]   r_pc;
  logic              r_gr_we;
  logic [DEST_W-1:0] r_dest;
  logic [31:0]       r_alu_res;
  logic [4:0]        r_load_op;
  logic              r_rfrom_mem;
  logic              r_req;
  logic [SIDE_W-1:0] r_side;
  logic              r_got;
  logic [31:0]       r_buf;
  logic [CW-1:0]     r_cancel_cnt;

  logic              w_cancel_idle;
  logic              w_cancel_full;
  logic              w_resp_mine;
  logic              w_ready_go;
  logic              w_kill_mem;
  logic              w_kill_exe;
  logic              w_dec;
  logic [1:0]        w_inc;
  logic [CW+1:0]     w_sum;
  logic [CW-1:0]     w_cancel_nxt;
  logic [31:0]       w_src;
  logic [31:0]       w_sh;
  logic [31:0]       w_fmt;

  assign w_cancel_idle = (r_cancel_cnt == '0);
  assign w_cancel_full = (r_cancel_cnt == CW'(MAX_CANCEL));
  // A response only belongs to this stage once every discarded one has drained.
  assign w_resp_mine   = data_ok & w_cancel_idle;
  assign w_ready_go    = !r_req | r_got | w_resp_mine;

  assign out_valid  = r_valid & w_ready_go & !flush;
  assign in_allowin = (!r_valid | (w_ready_go & out_allowin)) & !w_cancel_full;

  // Requests orphaned by a flush: the waiting one here and the one EXE just issued.
  assign w_kill_mem = r_valid & r_req & !r_got & !w_resp_mine;
  assign w_kill_exe = in_valid & in_req_sent;
  assign w_dec      = data_ok & !w_cancel_idle;

  // Cancel-counter next value: add flush kills, drop one per discarded response, saturate.
  always_comb begin
    w_inc = '0;
    if (flush) w_inc = 2'(w_kill_mem) + 2'(w_kill_exe);
    w_sum = (CW+2)'(r_cancel_cnt) + (CW+2)'(w_inc) - (CW+2)'(w_dec);
    w_cancel_nxt = (w_sum > (CW+2)'(MAX_CANCEL)) ? CW'(MAX_CANCEL) : w_sum[CW-1:0];
  end

  assign w_src = r_got ? r_buf : rdata;
  assign w_sh  = w_src >> {r_alu_res[1:0], 3'b000};

  // Load-data formatting by access width and signedness.
  always_comb begin
    w_fmt = w_sh;
    if (r_load_op[0])      w_fmt = {{24{w_sh[7]}}, w_sh[7:0]};
    else if (r_load_op[1]) w_fmt = {24'd0, w_sh[7:0]};
    else if (r_load_op[2]) w_fmt = {{16{w_sh[15]}}, w_sh[15:0]};
    else if (r_load_op[3]) w_fmt = {16'd0, w_sh[15:0]};
  end

  assign out_result = r_rfrom_mem ? w_fmt : r_alu_res;
  assign fwd_data   = out_result;
  assign fwd_dest   = (r_valid & r_gr_we) ? r_dest : '0;
  assign fwd_stall  = r_valid & r_rfrom_mem & !w_ready_go;
  assign out_pc     = r_pc;
  assign out_gr_we  = r_gr_we;
  assign out_dest   = r_dest;
  assign out_side   = r_side;

  // Stage registers, response buffer and cancel counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_gr_we      <= 1'b0;
      r_dest       <= '0;
      r_alu_res    <= '0;
      r_load_op    <= '0;
      r_rfrom_mem  <= 1'b0;
      r_req        <= 1'b0;
      r_side       <= '0;
      r_got        <= 1'b0;
      r_buf        <= '0;
      r_cancel_cnt <= '0;
    end else begin
      r_cancel_cnt <= w_cancel_nxt;
      if (flush) begin
        r_valid <= 1'b0;
      end else if (in_allowin) begin
        r_valid <= in_valid;
        if (in_valid) begin
          r_pc        <= in_pc;
          r_gr_we     <= in_gr_we;
          r_dest      <= in_dest;
          r_alu_res   <= in_alu_res;
          r_load_op   <= in_load_op;
          r_rfrom_mem <= in_rfrom_mem;
          r_req       <= in_req_sent;
          r_side      <= in_side;
          r_got       <= 1'b0;
        end
      end
      // Capture and buffering are exclusive: buffering needs !out_allowin with a valid entry.
      if (!flush && r_valid && r_req && !r_got && w_resp_mine && !out_allowin) begin
        r_buf <= rdata;
        r_got <= 1'b1;
      end
    end
  end

endmodule
